// File: rtl/mips_alu_muldiv_seq.sv
// Iterative HI/LO multiply/divide sequencer: shift-add multiplier and restoring
// divider, one bit per cycle, with sign fix-up applied on the final edge.
module mips_alu_muldiv_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              flush,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);
    // state | meaning
    // IDLE  | waiting for a request; mthi/mtlo complete here
    // CALC  | one multiply/divide iteration per edge, DATA_W edges
    // FIX   | sign correction and HI/LO write-back
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [2:0] OP_MULTS = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIVS  = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t state, state_next;
    logic [CNT_W-1:0]    counter;
    logic [2*DATA_W-1:0] work;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0]   operand;    // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   orig1;
    logic                is_div, neg_q, neg_r, zero_div;

    logic                accept, start, is_signed, sign1, sign2;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W:0]     mul_sum, rem_s, diff;
    logic [2*DATA_W-1:0] mul_next, div_next, prod;
    logic [DATA_W-1:0]   quo, rem;

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE) && !flush &&
                       (req_op != 3'd0) && (req_op != 3'd7);
    assign start     = accept && (req_op <= OP_DIVU);
    assign is_signed = (req_op == OP_MULTS) || (req_op == OP_DIVS);
    assign sign1     = is_signed && data1[DATA_W-1];
    assign sign2     = is_signed && data2[DATA_W-1];
    assign mag1      = sign1 ? -data1 : data1;
    assign mag2      = sign2 ? -data2 : data2;

    assign mul_sum  = {1'b0, work[2*DATA_W-1:DATA_W]} + (work[0] ? {1'b0, operand} : '0);
    assign mul_next = {mul_sum, work[DATA_W-1:1]};

    // A borrow out of the trial subtraction means the divisor did not fit.
    assign rem_s    = work[2*DATA_W-1:DATA_W-1];
    assign diff     = rem_s - {1'b0, operand};
    assign div_next = diff[DATA_W] ? {rem_s[DATA_W-1:0], work[DATA_W-2:0], 1'b0}
                                   : {diff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};

    assign prod = neg_q ? -work : work;
    assign quo  = neg_q ? -work[DATA_W-1:0] : work[DATA_W-1:0];
    assign rem  = neg_r ? -work[2*DATA_W-1:DATA_W] : work[2*DATA_W-1:DATA_W];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (flush) state_next = IDLE;
                     else if (counter == CNT_W'(DATA_W - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            counter  <= '0;
            work     <= '0;
            operand  <= '0;
            orig1    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && req_op == OP_MTHI) hi <= data1;
            if (accept && req_op == OP_MTLO) lo <= data1;
            if (start) begin
                is_div   <= (req_op == OP_DIVS) || (req_op == OP_DIVU);
                neg_q    <= sign1 ^ sign2;
                neg_r    <= sign1;
                zero_div <= (data2 == '0);
                orig1    <= data1;
                counter  <= '0;
                div_zero <= 1'b0;
                if ((req_op == OP_DIVS) || (req_op == OP_DIVU)) begin
                    operand <= mag2;
                    work    <= {{DATA_W{1'b0}}, mag1};
                end else begin
                    operand <= mag1;
                    work    <= {{DATA_W{1'b0}}, mag2};
                end
            end
            if (state == CALC && !flush) begin
                work    <= is_div ? div_next : mul_next;
                counter <= counter + 1'b1;
            end
            if (state == FIX && !flush) begin
                done <= 1'b1;
                if (!is_div) begin
                    hi <= prod[2*DATA_W-1:DATA_W];
                    lo <= prod[DATA_W-1:0];
                end else if (zero_div) begin
                    hi       <= orig1;
                    lo       <= '1;
                    div_zero <= 1'b1;
                end else begin
                    hi <= rem;
                    lo <= quo;
                end
            end
        end
    end
endmodule
